// File: rtl/conv_write_back_gen.sv
// Writeback controller: phase sequencer for the PSUM buffer plus a small output FIFO of packed row beats.
// Optional macro WB_RELU_EN clamps negative row results to zero before packing.
module conv_write_back_gen #(
  parameter int NUM_ROWS   = 16,
  parameter int DATA_W     = 25,
  parameter int LANE_W     = 32,
  parameter int DEPTH      = 61,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_init,
  input  logic                         p_filter_end,
  input  logic                         end_conv,
  input  logic [NUM_ROWS*DATA_W-1:0]   row_data,
  input  logic [NUM_ROWS-1:0]          row_valid,
  output logic                         p_init,
  output logic                         p_write_zero,
  output logic                         start_conv,
  output logic                         odd_cnt,
  output logic [NUM_ROWS*LANE_W-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         ovf,
  output logic                         end_op
);

  localparam int CNT_W = $clog2(DEPTH + 3);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = NUM_ROWS * LANE_W;

  localparam logic [3:0] S_IDLE             = 4'd0;
  localparam logic [3:0] S_INIT_BUFF        = 4'd1;
  localparam logic [3:0] S_START_CONV       = 4'd2;
  localparam logic [3:0] S_CLEAR_START_CONV = 4'd3;
  localparam logic [3:0] S_WAIT_ADD         = 4'd4;
  localparam logic [3:0] S_WAIT_WRITE0      = 4'd5;
  localparam logic [3:0] S_CLEAR_CNT        = 4'd6;
  localparam logic [3:0] S_ROW              = 4'd7;
  localparam logic [3:0] S_FINISH           = 4'd8;
  localparam logic [3:0] S_END_CONV         = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             end_latch_q, end_latch_d;
  logic             p_init_q, p_init_d;
  logic             start_conv_q, start_conv_d;
  logic             p_write_zero_q, p_write_zero_d;
  logic             odd_cnt_q, odd_cnt_d;
  logic             end_op_q, end_op_d;
  logic             ovf_q, ovf_d;

  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] beat_d;
  logic             push_req, pop, full, push_ok, drop;
  logic signed [DATA_W-1:0] row_val;

  wire phase_last = (cnt_q == CNT_W'(DEPTH - 1));

  // The START_CONV phase restarts its own count so it spans DEPTH+3 cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    end_latch_d = end_latch_q | end_conv;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_init) state_d = S_INIT_BUFF;
      end
      S_INIT_BUFF: begin
        if (phase_last) begin
          state_d = S_START_CONV;
          cnt_d   = '0;
        end
      end
      S_START_CONV:       if (cnt_q >= CNT_W'(DEPTH + 2)) state_d = S_CLEAR_START_CONV;
      S_CLEAR_START_CONV: begin
        cnt_d = '0;
        if (p_filter_end) state_d = S_WAIT_ADD;
      end
      S_WAIT_ADD:         if (phase_last) state_d = S_WAIT_WRITE0;
      S_WAIT_WRITE0:      state_d = S_CLEAR_CNT;
      S_CLEAR_CNT: begin
        cnt_d   = '0;
        state_d = S_ROW;
      end
      S_ROW:              if (phase_last) state_d = end_latch_q ? S_FINISH : S_CLEAR_START_CONV;
      S_FINISH: begin
        cnt_d       = '0;
        end_latch_d = 1'b0;
        if (count_q == '0) state_d = S_END_CONV;
      end
      S_END_CONV:         state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    p_init_d       = (state_q == S_INIT_BUFF);
    start_conv_d   = (state_q == S_START_CONV) || (state_q == S_CLEAR_CNT);
    p_write_zero_d = (state_q == S_ROW);
    end_op_d       = (state_q == S_END_CONV);
    odd_cnt_d      = odd_cnt_q ^ (state_q == S_CLEAR_CNT);
  end

  always_comb begin
    beat_d  = '0;
    row_val = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      row_val = row_data[i*DATA_W +: DATA_W];
`ifdef WB_RELU_EN
      if (row_val[DATA_W-1]) row_val = '0;
`endif
      beat_d[i*LANE_W +: LANE_W] = LANE_W'(row_val);
    end
  end

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  always_comb begin
    push_req = &row_valid;
    pop      = (count_q != '0) && out_ready;
    full     = (count_q == OCC_W'(FIFO_DEPTH));
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + OCC_W'(push_ok) - OCC_W'(pop);
    ovf_d    = ((state_q == S_IDLE && start_init) ? 1'b0 : ovf_q) | drop;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = beat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      end_latch_q    <= 1'b0;
      p_init_q       <= 1'b0;
      start_conv_q   <= 1'b0;
      p_write_zero_q <= 1'b0;
      odd_cnt_q      <= 1'b0;
      end_op_q       <= 1'b0;
      ovf_q          <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      end_latch_q    <= end_latch_d;
      p_init_q       <= p_init_d;
      start_conv_q   <= start_conv_d;
      p_write_zero_q <= p_write_zero_d;
      odd_cnt_q      <= odd_cnt_d;
      end_op_q       <= end_op_d;
      ovf_q          <= ovf_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mem_q          <= mem_d;
    end
  end

  assign p_init       = p_init_q;
  assign start_conv   = start_conv_q;
  assign p_write_zero = p_write_zero_q;
  assign odd_cnt      = odd_cnt_q;
  assign end_op       = end_op_q;
  assign ovf          = ovf_q;
  assign out_valid    = (count_q != '0);
  assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_conv_write_back_gen.sv
// Bench for conv_write_back_gen: phase timelines from cycle arithmetic, FIFO checked against a queue model.
module tb_conv_write_back_gen;

  localparam int NUM_ROWS   = 16;
  localparam int DATA_W     = 25;
  localparam int LANE_W     = 32;
  localparam int DEPTH      = 61;
  localparam int FIFO_DEPTH = 4;
  localparam int IW = NUM_ROWS * DATA_W;
  localparam int OW = NUM_ROWS * LANE_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_init = 1'b0, p_filter_end = 1'b0, end_conv = 1'b0, out_ready = 1'b0;
  logic [IW-1:0] row_data = '0;
  logic [NUM_ROWS-1:0] row_valid = '0;
  logic          p_init, p_write_zero, start_conv, odd_cnt, out_valid, ovf, end_op;
  logic [OW-1:0] out_data;

  int checks = 0;
  int failures = 0;

  logic [OW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  bit            idle_expected = 1'b0;
  bit            traffic_on = 1'b0;
  logic          odd_exp = 1'b0;

  always #5 clk = ~clk;

  conv_write_back_gen #(
    .NUM_ROWS(NUM_ROWS), .DATA_W(DATA_W), .LANE_W(LANE_W), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_init(start_init), .p_filter_end(p_filter_end),
    .end_conv(end_conv), .row_data(row_data), .row_valid(row_valid), .p_init(p_init),
    .p_write_zero(p_write_zero), .start_conv(start_conv), .odd_cnt(odd_cnt),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .end_op(end_op)
  );

  // Each row is read as a two's complement integer and written back as a lane value.
  function automatic logic [OW-1:0] pack(input logic [IW-1:0] rd);
    logic [OW-1:0] r;
    longint v;
    r = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      v = longint'(rd[i*DATA_W +: DATA_W]);
      if (v >= (longint'(1) << (DATA_W - 1))) v = v - (longint'(1) << DATA_W);
`ifdef WB_RELU_EN
      if (v < 0) v = 0;
`endif
      r[i*LANE_W +: LANE_W] = v[LANE_W-1:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic checkWide(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic randomRows();
    for (int i = 0; i < NUM_ROWS; i++) begin
      if ($urandom_range(0, 3) == 0) row_data[i*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
      else row_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
  endtask

  task automatic applyStimulus();
    if (traffic_on) begin
      randomRows();
      row_valid = ($urandom_range(0, 2) != 0) ? '1 : NUM_ROWS'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Queue model of the output FIFO and its overflow flag.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      automatic bit do_pop = (mq.size() != 0) && out_ready;
      automatic bit full   = (mq.size() == FIFO_DEPTH);
      if (start_init && idle_expected) m_ovf = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (&row_valid) begin
        if (full && !do_pop) m_ovf = 1'b1;
        else mq.push_back(pack(row_data));
      end
    end
  end

  always @(negedge clk) begin
    checkBit("out_valid", out_valid, mq.size() != 0);
    checkBit("ovf", ovf, m_ovf);
    if (mq.size() != 0) checkWide("out_data", out_data, mq[0]);
  end

  // Phase timelines, k counting negedges after the edge that sampled start_init or p_filter_end.
  task automatic timeline(input int kind, input int ncyc);
    logic e_pi, e_sc, e_pwz, e_odd, e_eo;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start_init = 1'b0;
        p_filter_end = 1'b0;
        idle_expected = 1'b0;
      end
      e_pi = 1'b0; e_sc = 1'b0; e_pwz = 1'b0; e_eo = 1'b0; e_odd = odd_exp;
      if (kind == 0) begin
        e_pi = (k >= 1 && k <= DEPTH);
        e_sc = (k >= DEPTH + 1 && k <= 2*DEPTH + 3);
      end else begin
        e_sc  = (k == DEPTH + 2);
        e_pwz = (k >= DEPTH + 3 && k <= 2*DEPTH + 2);
        e_odd = odd_exp ^ (k >= DEPTH + 2);
        e_eo  = (kind == 2 && k == 2*DEPTH + 12);
      end
      checkBit("p_init", p_init, e_pi);
      checkBit("start_conv", start_conv, e_sc);
      checkBit("p_write_zero", p_write_zero, e_pwz);
      checkBit("odd_cnt", odd_cnt, e_odd);
      checkBit("end_op", end_op, e_eo);
      if (kind == 2) begin
        if (k == 10) end_conv = 1'b1;
        if (k == 11) end_conv = 1'b0;
        if (k == 2*DEPTH + 8) out_ready = 1'b1;
      end
      applyStimulus();
    end
    if (kind != 0 && ncyc > DEPTH + 2) odd_exp = ~odd_exp;
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_p_init"}, p_init, 1'b0);
    checkBit({tag, "_start_conv"}, start_conv, 1'b0);
    checkBit({tag, "_p_write_zero"}, p_write_zero, 1'b0);
    checkBit({tag, "_odd_cnt"}, odd_cnt, 1'b0);
    checkBit({tag, "_end_op"}, end_op, 1'b0);
    checkBit({tag, "_out_valid"}, out_valid, 1'b0);
    checkBit({tag, "_ovf"}, ovf, 1'b0);
    checkWide({tag, "_out_data"}, out_data, '0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [OW-1:0] first_beat;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    idle_expected = 1'b1;
    traffic_on = 1'b1;

    // First pass under random row traffic and random backpressure.
    @(negedge clk);
    applyStimulus();
    row_valid = '0;
    start_init = 1'b1;
    timeline(0, 2*DEPTH + 6);

    @(negedge clk);
    applyStimulus();
    start_init = 1'b1;
    @(negedge clk);
    start_init = 1'b0;
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBit("ignored_start_init", p_init, 1'b0);
      applyStimulus();
    end
    @(negedge clk);
    applyStimulus();
    p_filter_end = 1'b1;
    timeline(1, 2*DEPTH + 6);

    // Last pass: two beats parked, end_conv during WAIT_ADD, FINISH waits for the drain.
    traffic_on = 1'b0;
    row_valid = '0;
    out_ready = 1'b1;
    repeat (FIFO_DEPTH + 2) @(negedge clk);
    checkBit("drained", out_valid, 1'b0);
    out_ready = 1'b0;
    randomRows();
    row_valid = '1;
    @(negedge clk);
    randomRows();
    @(negedge clk);
    row_valid = '0;
    p_filter_end = 1'b1;
    timeline(2, 2*DEPTH + 14);

    // Overflow: five beats into a four-entry FIFO with no consumer.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      randomRows();
      if (i == 0) first_beat = pack(row_data);
      row_valid = '1;
      @(negedge clk);
    end
    row_valid = '0;
    checkBit("ovf_after_overrun", ovf, 1'b1);
    checkOutput("model_depth", mq.size(), FIFO_DEPTH);
    checkWide("head_is_first_beat", out_data, first_beat);
    out_ready = 1'b1;
    repeat (FIFO_DEPTH + 1) @(negedge clk);
    checkBit("ovf_sticky", ovf, 1'b1);
    checkBit("empty_after_drain", out_valid, 1'b0);

    // Sign extension literals on lanes 0 and 1.
    randomRows();
    row_data[0 +: DATA_W] = 25'h1FFFFFF;
    row_data[DATA_W +: DATA_W] = 25'h0000005;
    row_valid = '1;
    @(negedge clk);
    row_valid = '0;
    checkBit("lit_valid", out_valid, 1'b1);
`ifdef WB_RELU_EN
    checkOutput("lit_lane0", out_data[0 +: LANE_W], 32'h00000000);
`else
    checkOutput("lit_lane0", out_data[0 +: LANE_W], 32'hFFFFFFFF);
`endif
    checkOutput("lit_lane1", out_data[LANE_W +: LANE_W], 32'h00000005);

    @(negedge clk);
    idle_expected = 1'b1;
    start_init = 1'b1;
    timeline(0, 2*DEPTH + 6);
    checkBit("ovf_cleared_by_start", ovf, 1'b0);

    // Reset in the middle of ROW with beats queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomRows();
      row_valid = '1;
      @(negedge clk);
    end
    row_valid = '0;
    p_filter_end = 1'b1;
    timeline(1, DEPTH + 20);
    checkBit("row_before_reset", p_write_zero, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    odd_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_expected = 1'b1;
    @(negedge clk);
    checkAllZero("after_release");
    start_init = 1'b1;
    timeline(0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
